// File: rtl/fosfor_present_ctrl.sv
// Host-side bus controller for the PRESENT datapath: assembles input bytes from
// nibble writes, steers block/key byte loads and sequences the encrypt/decrypt
// round schedule. Status_b = {Ptr, Err, Dec, Done, Busy}.
module fosfor_present_ctrl #(
  parameter int NROUNDS    = 31,
  parameter int NKEYBYTES  = 10,
  parameter int NDATABYTES = 8
) (
  input  logic       Clk_ik,
  input  logic       Reset_irn,
  input  logic [1:0] Addr_ib,
  input  logic [3:0] Data_ib,
  output logic [7:0] Data_ob,
  input  logic [7:0] DpOutData_ib,
  output logic [7:0] DpInData_ob,
  output logic [3:0] DpPtr_ob,
  output logic       DpWrData_o,
  output logic       DpWrKey_o,
  output logic       DpKeyStep_o,
  output logic       DpRound_o,
  output logic       DpFinal_o,
  output logic       DpDecrypt_o,
  output logic [4:0] DpRoundCnt_ob,
  output logic       Busy_o
);

  localparam logic [3:0] CMD_START_ENC = 4'h1;
  localparam logic [3:0] CMD_START_DEC = 4'h2;
  localparam logic [3:0] CMD_WR_DATA   = 4'h3;
  localparam logic [3:0] CMD_WR_KEY    = 4'h4;
  localparam logic [3:0] CMD_RD_NEXT   = 4'h5;
  localparam logic [3:0] CMD_PTR_CLR   = 4'h6;
  localparam logic [3:0] CMD_CLR_ERR   = 4'h7;
  localparam logic [3:0] CMD_ABORT     = 4'h8;

  typedef enum logic [2:0] {
    S_IDLE, S_KEYFWD, S_RUN, S_FINAL, S_DONE
  } state_t;

  state_t     state;
  logic [4:0] cnt;
  logic [3:0] ptr;
  logic [7:0] input_data;
  logic       dec;
  logic       err;
  logic       wr_data;
  logic       wr_key;
  logic       key_step;
  logic       round;
  logic       final_rk;
  logic       decrypt;

  logic       busy;
  logic       is_cmd;
  logic [3:0] ptr_base;
  logic [7:0] status;

  // Pointer increment modulo a byte count.
  function automatic logic [3:0] inc_mod(input logic [3:0] p, input int m);
    return 4'((int'(p) + 1) % m);
  endfunction

  assign busy   = (state == S_KEYFWD) || (state == S_RUN) || (state == S_FINAL);
  assign is_cmd = (Addr_ib == 2'b01);
  assign status = {ptr, err, dec, (state == S_DONE), busy};

  // Pointer after applying the post-increment owed by last cycle's write strobe.
  always_comb begin
    ptr_base = ptr;
    if (wr_data)
      ptr_base = inc_mod(ptr, NDATABYTES);
    else if (wr_key)
      ptr_base = inc_mod(ptr, NKEYBYTES);
  end

  // Control FSM, bus decode and all registered datapath controls.
  always_ff @(posedge Clk_ik or negedge Reset_irn) begin
    if (!Reset_irn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      input_data <= '0;
      dec        <= 1'b0;
      err        <= 1'b0;
      wr_data    <= 1'b0;
      wr_key     <= 1'b0;
      key_step   <= 1'b0;
      round      <= 1'b0;
      final_rk   <= 1'b0;
      decrypt    <= 1'b0;
    end else begin
      wr_data  <= 1'b0;
      wr_key   <= 1'b0;
      key_step <= 1'b0;
      round    <= 1'b0;
      final_rk <= 1'b0;
      ptr      <= ptr_base;

      if (Addr_ib == 2'b10) input_data[3:0] <= Data_ib;
      if (Addr_ib == 2'b11) input_data[7:4] <= Data_ib;

      // Round schedule sequencing.
      case (state)
        S_KEYFWD: begin
          if (cnt == 5'(NROUNDS)) begin
            state    <= S_FINAL;
            final_rk <= 1'b1;
          end else begin
            cnt      <= cnt + 5'd1;
            key_step <= 1'b1;
          end
        end
        S_RUN: begin
          if (dec) begin
            if (cnt == 5'd1) begin
              state   <= S_DONE;
              decrypt <= 1'b0;
            end else begin
              cnt   <= cnt - 5'd1;
              round <= 1'b1;
            end
          end else if (cnt == 5'(NROUNDS)) begin
            state    <= S_FINAL;
            final_rk <= 1'b1;
          end else begin
            cnt   <= cnt + 5'd1;
            round <= 1'b1;
          end
        end
        S_FINAL: begin
          if (dec) begin
            // Decrypt whitening comes first, then the inverse rounds.
            state <= S_RUN;
            cnt   <= 5'(NROUNDS);
            round <= 1'b1;
          end else begin
            state <= S_DONE;
          end
        end
        default: ;
      endcase

      // Host commands; while busy only ABORT and CLR_ERR are honoured.
      if (is_cmd) begin
        if (busy) begin
          case (Data_ib)
            CMD_START_ENC, CMD_START_DEC, CMD_WR_DATA,
            CMD_WR_KEY, CMD_RD_NEXT, CMD_PTR_CLR: err <= 1'b1;
            CMD_CLR_ERR: err <= 1'b0;
            CMD_ABORT: begin
              state    <= S_IDLE;
              cnt      <= '0;
              key_step <= 1'b0;
              round    <= 1'b0;
              final_rk <= 1'b0;
              decrypt  <= 1'b0;
            end
            default: ;
          endcase
        end else begin
          case (Data_ib)
            CMD_START_ENC: begin
              state   <= S_RUN;
              cnt     <= 5'd1;
              round   <= 1'b1;
              dec     <= 1'b0;
              decrypt <= 1'b0;
            end
            CMD_START_DEC: begin
              state    <= S_KEYFWD;
              cnt      <= 5'd1;
              key_step <= 1'b1;
              dec      <= 1'b1;
              decrypt  <= 1'b1;
            end
            CMD_WR_DATA: begin
              wr_data <= 1'b1;
              state   <= S_IDLE;
            end
            CMD_WR_KEY: begin
              wr_key <= 1'b1;
              state  <= S_IDLE;
            end
            CMD_RD_NEXT: ptr <= inc_mod(ptr_base, NDATABYTES);
            CMD_PTR_CLR: ptr <= '0;
            CMD_CLR_ERR: err <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

  assign Data_ob       = Addr_ib[1] ? DpOutData_ib : status;
  assign DpInData_ob   = input_data;
  assign DpPtr_ob      = ptr;
  assign DpWrData_o    = wr_data;
  assign DpWrKey_o     = wr_key;
  assign DpKeyStep_o   = key_step;
  assign DpRound_o     = round;
  assign DpFinal_o     = final_rk;
  assign DpDecrypt_o   = decrypt;
  assign DpRoundCnt_ob = cnt;
  assign Busy_o        = busy;

endmodule

// File: tb/tb_fosfor_present_ctrl.sv
// Directed bench for fosfor_present_ctrl: a cycle-level behavioural model
// (operation = elapsed cycle count since START) checked every cycle, plus
// literal expectations on the test-plan scenarios.
module tb_fosfor_present_ctrl;

  logic       Clk_ik = 1'b0;
  logic       Reset_irn = 1'b0;
  logic [1:0] Addr_ib = 2'b00;
  logic [3:0] Data_ib = 4'h0;
  logic [7:0] Data_ob;
  logic [7:0] DpOutData_ib = 8'h3C;
  logic [7:0] DpInData_ob;
  logic [3:0] DpPtr_ob;
  logic       DpWrData_o, DpWrKey_o, DpKeyStep_o, DpRound_o, DpFinal_o, DpDecrypt_o;
  logic [4:0] DpRoundCnt_ob;
  logic       Busy_o;

  fosfor_present_ctrl dut (
    .Clk_ik(Clk_ik), .Reset_irn(Reset_irn), .Addr_ib(Addr_ib), .Data_ib(Data_ib),
    .Data_ob(Data_ob), .DpOutData_ib(DpOutData_ib), .DpInData_ob(DpInData_ob),
    .DpPtr_ob(DpPtr_ob), .DpWrData_o(DpWrData_o), .DpWrKey_o(DpWrKey_o),
    .DpKeyStep_o(DpKeyStep_o), .DpRound_o(DpRound_o), .DpFinal_o(DpFinal_o),
    .DpDecrypt_o(DpDecrypt_o), .DpRoundCnt_ob(DpRoundCnt_ob), .Busy_o(Busy_o)
  );

  always #5 Clk_ik = ~Clk_ik;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // op: 0 none, 1 encrypt, 2 decrypt; t: cycles since the START edge (1 = first).
  int   m_op, m_t, m_ptr;
  bit   m_done, m_dec, m_err, m_wrd, m_wrk, m_busy_pre;
  logic [7:0] m_in;

  always @(posedge Clk_ik or negedge Reset_irn) begin
    if (!Reset_irn) begin
      m_op = 0; m_t = 0; m_ptr = 0; m_done = 0; m_dec = 0; m_err = 0;
      m_wrd = 0; m_wrk = 0; m_in = 8'h00;
    end else begin
      m_busy_pre = (m_op != 0);
      if (m_wrd) m_ptr = (m_ptr + 1) % 8;
      if (m_wrk) m_ptr = (m_ptr + 1) % 10;
      m_wrd = 0; m_wrk = 0;
      if (m_busy_pre) begin
        m_t++;
        if (m_t > ((m_op == 1) ? 32 : 63)) begin m_op = 0; m_done = 1; end
      end
      if (Addr_ib == 2'b10) m_in[3:0] = Data_ib;
      if (Addr_ib == 2'b11) m_in[7:4] = Data_ib;
      if (Addr_ib == 2'b01) begin
        if (m_busy_pre) begin
          if (Data_ib >= 4'h1 && Data_ib <= 4'h6) m_err = 1;
          else if (Data_ib == 4'h7) m_err = 0;
          else if (Data_ib == 4'h8) begin m_op = 0; m_done = 0; end
        end else begin
          case (Data_ib)
            4'h1: begin m_op = 1; m_t = 1; m_done = 0; m_dec = 0; end
            4'h2: begin m_op = 2; m_t = 1; m_done = 0; m_dec = 1; end
            4'h3: begin m_wrd = 1; m_done = 0; end
            4'h4: begin m_wrk = 1; m_done = 0; end
            4'h5: m_ptr = (m_ptr + 1) % 8;
            4'h6: m_ptr = 0;
            4'h7: m_err = 0;
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- compare process and pulse monitors ----------------
  int n_wrd, n_wrk, n_round, n_key, n_final;
  int wrd_ptrs[$];
  int wrk_ptrs[$];

  always @(negedge Clk_ik) begin
    bit er, ek, ef, eb;
    int ec;
    logic [7:0] est;
    if (chk_en) begin
      er = (m_op == 1 && m_t >= 1 && m_t <= 31) || (m_op == 2 && m_t >= 33 && m_t <= 63);
      ek = (m_op == 2 && m_t >= 1 && m_t <= 31);
      ef = (m_op != 0 && m_t == 32);
      eb = (m_op != 0);
      ec = (m_op == 2 && m_t >= 33) ? 64 - m_t : m_t;
      est = {4'(m_ptr), m_err, m_dec, m_done, eb};
      check("round", DpRound_o, er);
      check("keystep", DpKeyStep_o, ek);
      check("final", DpFinal_o, ef);
      check("busy", Busy_o, eb);
      check("decrypt", DpDecrypt_o, (m_op == 2));
      check("wrdata", DpWrData_o, m_wrd);
      check("wrkey", DpWrKey_o, m_wrk);
      check("ptr", DpPtr_ob, m_ptr);
      check("indata", DpInData_ob, m_in);
      check("data_ob", Data_ob, Addr_ib[1] ? DpOutData_ib : est);
      if (er || ek) check("roundcnt", DpRoundCnt_ob, ec);
    end
    if (DpWrData_o) begin n_wrd++; wrd_ptrs.push_back(DpPtr_ob); end
    if (DpWrKey_o) begin n_wrk++; wrk_ptrs.push_back(DpPtr_ob); end
    if (DpRound_o) n_round++;
    if (DpKeyStep_o) n_key++;
    if (DpFinal_o) n_final++;
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic [1:0] a, input logic [3:0] d);
    @(posedge Clk_ik);
    #1;
    Addr_ib = a;
    Data_ib = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(2'b00, 4'h0);
  endtask

  task automatic clr_mon();
    n_wrd = 0; n_wrk = 0; n_round = 0; n_key = 0; n_final = 0;
    wrd_ptrs.delete();
    wrk_ptrs.delete();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_data_ob", Data_ob, 8'h00);
    check("rst_indata", DpInData_ob, 8'h00);
    repeat (2) @(posedge Clk_ik);
    #1 Reset_irn = 1'b1;
    chk_en = 1'b1;
    idle(2);
    $display("TXN reset released status=0x%02h", Data_ob);

    // Nibble assembly and 8 block-byte writes
    bus(2'b10, 4'hA);
    bus(2'b11, 4'h5);
    clr_mon();
    for (int i = 0; i < 8; i++) begin bus(2'b01, 4'h3); bus(2'b00, 4'h0); end
    idle(2);
    check("indata_5a", DpInData_ob, 8'h5A);
    check("n_wrdata", n_wrd, 8);
    for (int i = 0; i < 8; i++) check("wrdata_ptr", (i < wrd_ptrs.size()) ? wrd_ptrs[i] : -1, i);
    check("ptr_wrap0", Data_ob, 8'h00);
    $display("TXN wr_data x8 indata=0x%02h pulses=%0d status=0x%02h", DpInData_ob, n_wrd, Data_ob);

    // 11 key-byte writes: pointers 0..9 then 0
    clr_mon();
    for (int i = 0; i < 11; i++) begin bus(2'b01, 4'h4); bus(2'b00, 4'h0); end
    idle(2);
    check("n_wrkey", n_wrk, 11);
    for (int i = 0; i < 11; i++) check("wrkey_ptr", (i < wrk_ptrs.size()) ? wrk_ptrs[i] : -1, i % 10);
    check("key_status", Data_ob, 8'h10);
    $display("TXN wr_key x11 pulses=%0d status=0x%02h", n_wrk, Data_ob);

    // Encrypt
    bus(2'b01, 4'h6);
    idle(1);
    clr_mon();
    bus(2'b01, 4'h1);
    idle(32);
    check("enc_busy_n31", Data_ob, 8'h01);
    idle(1);
    check("enc_status", Data_ob, 8'h02);
    check("enc_rounds", n_round, 31);
    check("enc_final", n_final, 1);
    $display("TXN encrypt rounds=%0d final=%0d status=0x%02h", n_round, n_final, Data_ob);

    // Decrypt
    clr_mon();
    bus(2'b01, 4'h2);
    idle(63);
    check("dec_busy_n62", Data_ob, 8'h05);
    idle(1);
    check("dec_status", Data_ob, 8'h06);
    check("dec_keysteps", n_key, 31);
    check("dec_final", n_final, 1);
    check("dec_rounds", n_round, 31);
    $display("TXN decrypt keysteps=%0d final=%0d rounds=%0d status=0x%02h", n_key, n_final, n_round, Data_ob);

    // Datapath read mux
    DpOutData_ib = 8'hC7;
    bus(2'b11, 4'h9);
    #1 check("rd_mux", Data_ob, 8'hC7);
    idle(1);
    $display("TXN read mux data_ob=0x%02h indata=0x%02h", DpOutData_ib, DpInData_ob);

    // Command while busy, then ABORT and CLR_ERR
    clr_mon();
    bus(2'b01, 4'h1);
    idle(9);
    bus(2'b01, 4'h3);
    idle(1);
    check("err_status", Data_ob, 8'h09);
    bus(2'b01, 4'h8);
    idle(1);
    check("abort_status", Data_ob, 8'h08);
    check("abort_round", DpRound_o, 0);
    check("busy_no_wr", n_wrd, 0);
    bus(2'b01, 4'h7);
    idle(1);
    check("clrerr_status", Data_ob, 8'h00);
    $display("TXN abort/clr_err status=0x%02h", Data_ob);

    // Asynchronous reset in the middle of a decrypt
    bus(2'b01, 4'h2);
    idle(20);
    check("pre_rst_keystep", DpKeyStep_o, 1);
    @(posedge Clk_ik);
    #3 Reset_irn = 1'b0;
    #1;
    check("rst_keystep", DpKeyStep_o, 0);
    check("rst_decrypt", DpDecrypt_o, 0);
    check("rst_busy", Busy_o, 0);
    check("rst_cnt", DpRoundCnt_ob, 0);
    check("rst_status", Data_ob, 8'h00);
    @(posedge Clk_ik);
    #1 Reset_irn = 1'b1;
    idle(2);
    $display("TXN mid-decrypt reset status=0x%02h", Data_ob);

    // RD_NEXT in idle
    bus(2'b01, 4'h5);
    idle(1);
    check("rdnext_status", Data_ob, 8'h10);
    $display("TXN rd_next status=0x%02h", Data_ob);

    idle(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fosfor_present_ctrl.md
# fosfor_present_ctrl

Host-side controller for the PRESENT cipher datapath on the 8-pin tile. It decodes the 2-bit address / 4-bit data bus, assembles input bytes, and steers byte loads of block and key into the datapath. It sequences the 31-round encrypt or decrypt schedule and exposes a status byte. It sits between the top-level pin mapping and the round/key datapath.

## Interface
Parameters:
- NROUNDS, 31: number of cipher rounds; the round counter is 5 bits wide.
- NKEYBYTES, 10: key length in bytes, used for key-pointer wrap.
- NDATABYTES, 8: block length in bytes, used for data-pointer wrap.

Ports:
- Clk_ik  in  1  system clock; every rising edge is a bus cycle.
- Reset_irn  in  1  asynchronous active-low reset.
- Addr_ib  in  2  bus address (00 idle, 01 command, 10 data low nibble, 11 data high nibble).
- Data_ib  in  4  bus write nibble.
- Data_ob  out  8  read mux: Status_b when Addr_ib[1]=0, else DpOutData_ib (combinational).
- DpOutData_ib  in  8  datapath byte selected by DpPtr_ob.
- DpInData_ob  out  8  assembled input byte register.
- DpPtr_ob  out  4  byte pointer for datapath loads and reads.
- DpWrData_o  out  1  one-cycle strobe: load DpInData_ob into block byte DpPtr_ob[2:0].
- DpWrKey_o  out  1  one-cycle strobe: load DpInData_ob into key byte DpPtr_ob.
- DpKeyStep_o  out  1  advance the key schedule only (decrypt pre-roll).
- DpRound_o  out  1  execute one round with counter DpRoundCnt_ob.
- DpFinal_o  out  1  final round-key XOR.
- DpDecrypt_o  out  1  1 = inverse rounds / inverse key schedule.
- DpRoundCnt_ob  out  5  current round counter.
- Busy_o  out  1  operation in progress.

## Operation
- Addr 10 writes Data_ib to InputData[3:0]. Addr 11 writes it to InputData[7:4]. Both writes are accepted in any state.
- Addr 01 decodes Data_ib as a command in the same edge:
  - 0x1 START_ENC.
  - 0x2 START_DEC.
  - 0x3 WR_DATA: DpWrData_o is asserted, then Ptr = (Ptr+1) mod 8.
  - 0x4 WR_KEY: DpWrKey_o is asserted, then Ptr = (Ptr+1) mod 10.
  - 0x5 RD_NEXT: Ptr = (Ptr+1) mod 8.
  - 0x6 PTR_CLR: Ptr = 0.
  - 0x7 CLR_ERR.
  - 0x8 ABORT.
  - Other codes are ignored.
- WR strobes are registered and last exactly one cycle. DpPtr_ob holds the pre-increment value during the strobe; Ptr updates one cycle later.
- Status_b layout: [0] Busy, [1] Done, [2] Dec (mode of last start), [3] Err, [7:4] Ptr.
- FSM states are IDLE, KEYFWD, RUN, FINAL, DONE. DONE behaves like IDLE but with Done=1.
- START_ENC from IDLE/DONE:
  - RUN with cnt 1..31 ascending, DpRound_o=1.
  - Then FINAL for 1 cycle.
  - Then DONE.
- START_DEC from IDLE/DONE:
  - KEYFWD with cnt 1..31, DpKeyStep_o=1.
  - Then FINAL for 1 cycle.
  - Then RUN with cnt 31..1 descending, DpRound_o=1.
  - Then DONE.
  - DpDecrypt_o=1 throughout.
- Any command other than ABORT, CLR_ERR or RD_NEXT while Busy sets Err (sticky) and is otherwise ignored. RD_NEXT while Busy also sets Err.
- ABORT while Busy: next edge goes to IDLE, all Dp strobes low, Done=0, Ptr unchanged. ABORT in IDLE/DONE is a no-op.
- Done clears on START_*, WR_DATA or WR_KEY. Err clears only on CLR_ERR or reset.
- Round counter arithmetic:
  - 5-bit ascending counter leaves RUN after cnt==NROUNDS.
  - Descending counter leaves RUN after cnt==1.
  - No wrap.

## Timing
- Reset values: all registered outputs 0; state IDLE; Ptr=0; InputData=0; Status_b=0x00.
- Reset takes effect asynchronously, including mid-operation; strobes drop immediately.
- All Dp* control outputs are registered. A START seen at edge N gives the first DpRound_o/DpKeyStep_o in the cycle after edge N.
- Encrypt: 31 round cycles plus 1 FINAL cycle. Busy_o is high for 32 cycles; Done=1 after edge N+32.
- Decrypt: 31 + 1 + 31 cycles. Busy_o is high for 63 cycles; Done=1 after edge N+63.
- Data_ob is combinational from Addr_ib, Status_b and DpOutData_ib, with no added latency.
- A nibble write and a status read of the same cycle: the new Status_b/InputData is visible after the edge.

## Test plan
- Reset with Reset_irn low mid-decrypt -> all Dp* outputs 0 immediately; Data_ob=0x00 with Addr 00.
- Addr 10 data 0xA, Addr 11 data 0x5, then cmd 0x3 ×8 -> DpInData_ob=0x5A; 8 one-cycle DpWrData_o pulses with Ptr 0..7; Ptr wraps to 0.
- Cmd 0x4 ×11 -> DpWrKey_o pointers 0..9 then 0; Status[7:4] ends at 1.
- START_ENC -> DpRound_o for exactly 31 cycles with cnt 1..31, DpFinal_o for 1 cycle; Status=0x02 after 32 edges (Ptr=0).
- START_DEC -> 31 DpKeyStep_o cycles (cnt 1..31), 1 DpFinal_o cycle, 31 DpRound_o cycles (cnt 31..1), DpDecrypt_o high throughout; Status=0x06 after 63 edges.
- START_ENC, then at cycle 10 cmd 0x3 -> Err=1 and no DpWrData_o; then ABORT -> IDLE next edge, Status=0x08; CLR_ERR -> Status=0x00.
